// File: rtl/div_iter.sv
// div_iter: sequential signed divider, one restoring quotient bit per cycle, sign fix-up at the end
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;
  stateT state, nextState;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] dvd, dvs, rem, remShift;
  logic aSign, qSign, goRun, lastIter, fits;
  assign goRun = start && (b != '0);
  assign lastIter = count == CW'(WIDTH - 1);
  assign remShift = {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign fits = remShift >= dvs;
  always_ff @(posedge clk)
    state <= reset ? IDLE : nextState;
  always_comb
    nextState = state == IDLE ? (goRun ? RUN : IDLE) :
                state == RUN  ? (lastIter ? FIX : RUN) : IDLE;
  always_comb
    busy = state == RUN;
  // dvd doubles as the quotient register: dividend bits shift out as quotient bits shift in
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      div_zero <= 1'b0;
      count <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      aSign <= 1'b0;
      qSign <= 1'b0;
    end else begin
      done <= state == FIX;
      div_zero <= state == IDLE && start && b == '0;
      if (state == IDLE && goRun) begin
        dvd <= a[WIDTH-1] ? -a : a;
        dvs <= b[WIDTH-1] ? -b : b;
        aSign <= a[WIDTH-1];
        qSign <= a[WIDTH-1] ^ b[WIDTH-1];
        rem <= '0;
        count <= '0;
      end
      if (state == RUN) begin
        rem <= fits ? remShift - dvs : remShift;
        dvd <= {dvd[WIDTH-2:0], fits};
        count <= count + 1'b1;
      end
      if (state == FIX) begin
        lo <= qSign ? -dvd : dvd;
        hi <= aSign ? -rem : rem;
      end
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter; a 64-bit signed model predicts hi/lo
module tb_div_iter;
  logic clk = 0, reset = 1, start = 0;
  logic [31:0] a = '0, b = '0, hi, lo;
  logic busy, done, div_zero;
  int nChecks = 0, nPass = 0;
  typedef struct {logic [31:0] hi, lo;} resT;
  resT sbQ[$];

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic resT model(input logic [31:0] x, input logic [31:0] y);
    longint sa, sb, q, r;
    resT res;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    q = sa / sb;
    r = sa % sb;
    res.lo = q[31:0];
    res.hi = r[31:0];
    return res;
  endfunction

  always @(negedge clk) begin
    if (done || div_zero) check("done/div_zero exclusive", {31'b0, done & div_zero}, 32'd0);
    if (done) begin
      if (sbQ.size() == 0) check("spurious done", 32'd1, 32'd0);
      else begin
        resT e;
        e = sbQ.pop_front();
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
      end
    end
  end

  task automatic runDiv(input logic [31:0] x, input logic [31:0] y, input bit extraStart);
    int lat, busyCnt;
    @(negedge clk);
    a = x; b = y; start = 1;
    sbQ.push_back(model(x, y));
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom;
    lat = 0; busyCnt = 0;
    while (!done && lat < 40) begin
      busyCnt += int'(busy);
      start = extraStart && lat == 5;
      @(negedge clk);
      lat++;
    end
    start = 0;
    check("latency", lat, 33);
    check("busy cycles", busyCnt, 32);
    check("busy low at done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("done pulse width", {31'b0, done}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset flags", {29'b0, busy, done, div_zero}, 0);
    reset = 0;
    runDiv(32'd7, 32'd2, 0);
    runDiv(32'hFFFF_FFF9, 32'd2, 0);
    runDiv(32'd7, 32'hFFFF_FFFE, 0);
    runDiv(32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
    runDiv(32'h8000_0000, 32'hFFFF_FFFF, 0);
    runDiv(32'd0, 32'd5, 0);
    runDiv(32'd7, 32'd2, 0);
    // divide by zero leaves hi/lo holding 1/3
    @(negedge clk);
    a = 32'd9; b = 32'd0; start = 1;
    @(negedge clk);
    start = 0;
    check("div_zero pulse", {31'b0, div_zero}, 32'd1);
    check("div_zero busy", {31'b0, busy}, 32'd0);
    check("div_zero done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("div_zero one cycle", {31'b0, div_zero}, 32'd0);
    check("div_zero busy later", {31'b0, busy}, 32'd0);
    check("hold hi", hi, 32'd1);
    check("hold lo", lo, 32'd3);
    // reset in the middle of an operation
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midreset hi", hi, 0);
    check("midreset lo", lo, 0);
    check("midreset flags", {29'b0, busy, done, div_zero}, 0);
    repeat (40) @(negedge clk);
    check("no done after reset", {31'b0, busy}, 32'd0);
    runDiv(32'd100, 32'd7, 1);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom;
      if (i % 2 == 1) y = y >> $urandom_range(31, 16);
      if (y == 0) y = 32'd3;
      runDiv(x, y, i == 2);
    end
    check("scoreboard empty", sbQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
